// File: rtl/tick_divider.sv
// tick_divider: runtime-programmable tick generator.
//
// Divides clk by a programmable ratio D. It produces a one-cycle `tick` once per D enabled
// cycles and a 50 % square wave `sq` that toggles on every tick. A new divisor is staged in a
// shadow register and swapped in on a terminal count, so a period never ends early.
//
// Optional feature macro: TICK_DIVIDER_CASCADE_EN. When it is defined, a cascade counter
// produces `slow_tick` once every SLOW_DIV ticks. When it is not defined, `slow_tick` is
// tied to 0 and the port list does not change.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   en        in   count enable
//   clr       in   synchronous clear (highest priority)
//   div_load  in   request a divisor change
//   div_in    in   new divisor [CNT_W]; 0 is treated as 1
//   pending   out  a loaded divisor is waiting for the next terminal count
//   tick      out  one-cycle pulse per divisor period
//   sq        out  square wave, toggles on each tick
//   slow_tick out  one-cycle pulse every SLOW_DIV ticks (cascade build only)
module tick_divider #(
  parameter int unsigned CNT_W       = 19,
  parameter int unsigned DIV_DEFAULT = 500000,
  parameter int unsigned SLOW_W      = 7,
  parameter int unsigned SLOW_DIV    = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_in,
  output logic             pending,
  output logic             tick,
  output logic             sq,
  output logic             slow_tick
);

  localparam logic [CNT_W-1:0] DivReset = CNT_W'(DIV_DEFAULT);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_act_q, div_act_d;  // divisor of the running period
  logic [CNT_W-1:0] div_sh_q, div_sh_d;    // staged divisor awaiting a swap
  logic             pending_q, pending_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;

  logic [CNT_W-1:0] div_clamped;
  logic             terminal;
  logic             tick_set;

  // A zero divisor would make the terminal count unreachable; treat it as 1.
  assign div_clamped = (div_in == '0) ? CntOne : div_in;

  // div_act_q is never 0, so the subtraction cannot underflow.
  assign terminal = (cnt_q == (div_act_q - CntOne));
  assign tick_set = ~clr & en & terminal;

  always_comb begin
    cnt_d     = cnt_q;
    div_act_d = div_act_q;
    div_sh_d  = div_sh_q;
    pending_d = pending_q;
    tick_d    = 1'b0;
    sq_d      = sq_q;

    if (clr) begin
      cnt_d = '0;
      sq_d  = 1'b0;
      if (pending_q) begin
        div_act_d = div_sh_q;
        pending_d = 1'b0;
      end
      // A load that coincides with clear applies immediately, since a new period starts anyway.
      if (div_load) begin
        div_act_d = div_clamped;
        div_sh_d  = div_clamped;
        pending_d = 1'b0;
      end
    end else begin
      if (en) begin
        if (terminal) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          sq_d   = ~sq_q;
          if (pending_q) begin
            div_act_d = div_sh_q;
            pending_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      // A load after the swap above re-arms pending, so a load on the terminal-count edge
      // takes effect at the following terminal count.
      if (div_load) begin
        div_sh_d  = div_clamped;
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      div_act_q <= DivReset;
      div_sh_q  <= DivReset;
      pending_q <= 1'b0;
      tick_q    <= 1'b0;
      sq_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_act_q <= div_act_d;
      div_sh_q  <= div_sh_d;
      pending_q <= pending_d;
      tick_q    <= tick_d;
      sq_q      <= sq_d;
    end
  end

  assign pending = pending_q;
  assign tick    = tick_q;
  assign sq      = sq_q;

`ifdef TICK_DIVIDER_CASCADE_EN
  localparam logic [SLOW_W-1:0] SlowLast = SLOW_W'(SLOW_DIV - 1);
  localparam logic [SLOW_W-1:0] SlowOne  = SLOW_W'(1);

  logic [SLOW_W-1:0] slow_cnt_q, slow_cnt_d;
  logic              slow_tick_q, slow_tick_d;

  // Advances only on edges that set tick, so it inherits the enable stretching for free.
  always_comb begin
    slow_cnt_d  = slow_cnt_q;
    slow_tick_d = 1'b0;
    if (clr) begin
      slow_cnt_d = '0;
    end else if (tick_set) begin
      if (slow_cnt_q == SlowLast) begin
        slow_cnt_d  = '0;
        slow_tick_d = 1'b1;
      end else begin
        slow_cnt_d = slow_cnt_q + SlowOne;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slow_cnt_q  <= '0;
      slow_tick_q <= 1'b0;
    end else begin
      slow_cnt_q  <= slow_cnt_d;
      slow_tick_q <= slow_tick_d;
    end
  end

  assign slow_tick = slow_tick_q;
`else
  logic unused_tick_set;
  assign unused_tick_set = tick_set;

  // The cascade parameters stay referenced so both builds elaborate the same parameter set.
  assign slow_tick = 1'b0 & (SLOW_DIV == SLOW_W) & unused_tick_set;
`endif

endmodule

// File: tb/tb_tick_divider.sv
module tb_tick_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic       div_load;
  logic [3:0] div_in;
  logic       pending;
  logic       tick;
  logic       sq;
  logic       slow_tick;

  int   n_cmp = 0;
  int   n_err = 0;
  logic m_sq;

`ifdef TICK_DIVIDER_CASCADE_EN
  localparam bit Casc = 1'b1;
`else
  localparam bit Casc = 1'b0;
`endif

  tick_divider #(
    .CNT_W      (4),
    .DIV_DEFAULT(5),
    .SLOW_W     (4),
    .SLOW_DIV   (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (clr),
    .div_load (div_load),
    .div_in   (div_in),
    .pending  (pending),
    .tick     (tick),
    .sq       (sq),
    .slow_tick(slow_tick)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; div_load = 1'b0; div_in = 4'd0;
    #2;
    n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL reset_tick got %b want 0", tick); end
    n_cmp++; if (sq !== 1'b0) begin n_err++; $display("FAIL reset_sq got %b want 0", sq); end
    n_cmp++; if (pending !== 1'b0) begin n_err++; $display("FAIL reset_pending got %b want 0", pending); end
    n_cmp++; if (slow_tick !== 1'b0) begin n_err++; $display("FAIL reset_slow got %b want 0", slow_tick); end
    step(); step();
    n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL reset_hold_tick got %b want 0", tick); end
    m_sq = 1'b0;
  endtask

  // D=5 from reset: ticks on edges 5, 10, 15; sq 1,0,1.
  task automatic test_basic();
    logic exp_t;
    rst_n = 1'b1; en = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      step();
      exp_t = ((e % 5) == 0);
      if (exp_t) m_sq = ~m_sq;
      n_cmp++; if (tick !== exp_t) begin n_err++; $display("FAIL basic_tick e=%0d got %b want %b", e, tick, exp_t); end
      n_cmp++; if (sq !== m_sq) begin n_err++; $display("FAIL basic_sq e=%0d got %b want %b", e, sq, m_sq); end
    end
  endtask

  // Load 3 on edge 2 of a D=5 period: pending edges 2..4, ticks at 5, 8, 11.
  task automatic test_reload();
    logic [11:0] exp_tick;
    logic [11:0] exp_pend;
    exp_tick = 12'h920;
    exp_pend = 12'h01C;
    div_in = 4'd3;
    for (int e = 1; e <= 11; e++) begin
      div_load = (e == 2);
      step();
      if (exp_tick[e]) m_sq = ~m_sq;
      n_cmp++; if (tick !== exp_tick[e]) begin n_err++; $display("FAIL reload_tick e=%0d got %b want %b", e, tick, exp_tick[e]); end
      n_cmp++; if (pending !== exp_pend[e]) begin n_err++; $display("FAIL reload_pending e=%0d got %b want %b", e, pending, exp_pend[e]); end
    end
    div_load = 1'b0;
    n_cmp++; if (sq !== m_sq) begin n_err++; $display("FAIL reload_sq got %b want %b", sq, m_sq); end
  endtask

  // D=3, load 0 on edge 1: swap at edge 3, then tick every edge with sq toggling.
  task automatic test_div_zero();
    logic [10:0] exp_tick;
    logic [10:0] exp_pend;
    exp_tick = 11'h7F8;
    exp_pend = 11'h006;
    div_in = 4'd0;
    for (int e = 1; e <= 10; e++) begin
      div_load = (e == 1);
      step();
      if (exp_tick[e]) m_sq = ~m_sq;
      n_cmp++; if (tick !== exp_tick[e]) begin n_err++; $display("FAIL zero_tick e=%0d got %b want %b", e, tick, exp_tick[e]); end
      n_cmp++; if (pending !== exp_pend[e]) begin n_err++; $display("FAIL zero_pending e=%0d got %b want %b", e, pending, exp_pend[e]); end
      n_cmp++; if (sq !== m_sq) begin n_err++; $display("FAIL zero_sq e=%0d got %b want %b", e, sq, m_sq); end
    end
    div_load = 1'b0;
  endtask

  task automatic test_clr();
    logic exp_t;
    // D=1: stage 2, then clear with a coincident load of 5; 5 must win.
    div_load = 1'b1; div_in = 4'd2;
    step();
    m_sq = ~m_sq;
    n_cmp++; if (pending !== 1'b1) begin n_err++; $display("FAIL clr_pre_pending got %b want 1", pending); end
    n_cmp++; if (tick !== 1'b1) begin n_err++; $display("FAIL clr_pre_tick got %b want 1", tick); end
    clr = 1'b1; div_in = 4'd5;
    step();
    m_sq = 1'b0;
    n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL clrld_tick got %b want 0", tick); end
    n_cmp++; if (sq !== 1'b0) begin n_err++; $display("FAIL clrld_sq got %b want 0", sq); end
    n_cmp++; if (pending !== 1'b0) begin n_err++; $display("FAIL clrld_pending got %b want 0", pending); end
    clr = 1'b0; div_load = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step();
      exp_t = (e == 5);
      if (exp_t) m_sq = ~m_sq;
      n_cmp++; if (tick !== exp_t) begin n_err++; $display("FAIL clrld_period e=%0d got %b want %b", e, tick, exp_t); end
    end
    // Stage 4, then a plain clear applies it.
    div_load = 1'b1; div_in = 4'd4;
    step();
    div_load = 1'b0;
    n_cmp++; if (pending !== 1'b1) begin n_err++; $display("FAIL clr_stage_pending got %b want 1", pending); end
    clr = 1'b1;
    step();
    clr = 1'b0;
    m_sq = 1'b0;
    n_cmp++; if (sq !== 1'b0) begin n_err++; $display("FAIL clr_sq got %b want 0", sq); end
    n_cmp++; if (pending !== 1'b0) begin n_err++; $display("FAIL clr_pending got %b want 0", pending); end
    for (int e = 1; e <= 4; e++) begin
      step();
      exp_t = (e == 4);
      if (exp_t) m_sq = ~m_sq;
      n_cmp++; if (tick !== exp_t) begin n_err++; $display("FAIL clr_period e=%0d got %b want %b", e, tick, exp_t); end
    end
  endtask

  // D=5, en low on edges 3..6: the tick moves from edge 5 to edge 9.
  task automatic test_enable();
    logic exp_t;
    clr = 1'b1; div_load = 1'b1; div_in = 4'd5;
    step();
    clr = 1'b0; div_load = 1'b0;
    m_sq = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      en = !(e >= 3 && e <= 6);
      step();
      exp_t = (e == 9);
      if (exp_t) m_sq = ~m_sq;
      n_cmp++; if (tick !== exp_t) begin n_err++; $display("FAIL enable_tick e=%0d got %b want %b", e, tick, exp_t); end
      n_cmp++; if (sq !== m_sq) begin n_err++; $display("FAIL enable_sq e=%0d got %b want %b", e, sq, m_sq); end
    end
    en = 1'b1;
  endtask

  // D=2, SLOW_DIV=3: slow_tick on edges 6 and 12 in the cascade build, never otherwise.
  task automatic test_cascade();
    logic exp_t;
    logic exp_s;
    clr = 1'b1; div_load = 1'b1; div_in = 4'd2;
    step();
    clr = 1'b0; div_load = 1'b0;
    m_sq = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step();
      exp_t = ((e % 2) == 0);
      exp_s = Casc && (e == 6 || e == 12);
      if (exp_t) m_sq = ~m_sq;
      n_cmp++; if (tick !== exp_t) begin n_err++; $display("FAIL casc_tick e=%0d got %b want %b", e, tick, exp_t); end
      n_cmp++; if (slow_tick !== exp_s) begin n_err++; $display("FAIL casc_slow e=%0d got %b want %b", e, slow_tick, exp_s); end
    end
  endtask

  // Reset right after a tick with a load staged; after release the period is DIV_DEFAULT.
  task automatic test_reset_mid();
    logic exp_t;
    step();
    div_load = 1'b1; div_in = 4'd7;
    step();
    div_load = 1'b0;
    m_sq = ~m_sq;
    n_cmp++; if (tick !== 1'b1) begin n_err++; $display("FAIL mid_pre_tick got %b want 1", tick); end
    n_cmp++; if (pending !== 1'b1) begin n_err++; $display("FAIL mid_pre_pending got %b want 1", pending); end
    n_cmp++; if (sq !== m_sq) begin n_err++; $display("FAIL mid_pre_sq got %b want %b", sq, m_sq); end
    rst_n = 1'b0;
    #1;
    m_sq = 1'b0;
    n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL mid_tick got %b want 0", tick); end
    n_cmp++; if (pending !== 1'b0) begin n_err++; $display("FAIL mid_pending got %b want 0", pending); end
    n_cmp++; if (sq !== 1'b0) begin n_err++; $display("FAIL mid_sq got %b want 0", sq); end
    step(); step();
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      exp_t = (e == 5);
      if (exp_t) m_sq = ~m_sq;
      n_cmp++; if (tick !== exp_t) begin n_err++; $display("FAIL mid_period e=%0d got %b want %b", e, tick, exp_t); end
      n_cmp++; if (sq !== m_sq) begin n_err++; $display("FAIL mid_period_sq e=%0d got %b want %b", e, sq, m_sq); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reload();
    test_div_zero();
    test_clr();
    test_enable();
    test_cascade();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tick_divider.md
# tick_divider

Parametrised, runtime-programmable clock-tick generator; successor to the fixed-limit centisecond divider. Divides the system clock by a programmable ratio and produces a one-cycle tick pulse plus a 50 % square wave. Supports enable, synchronous clear and glitch-free divisor reload, with an optional cascaded slow-tick stage. Feeds timekeeping logic (stopwatch/clock counters, display scan, debouncers) from one 50 MHz clock.

## Interface
Parameters:
- `CNT_W`, 19: width of the divisor and main counter.
- `DIV_DEFAULT`, 500000: divisor after reset; at 50 MHz this gives a centisecond tick.
- `SLOW_W`, 7: width of the cascade counter; used only with the cascade feature.
- `SLOW_DIV`, 100: base ticks per slow tick; must be ≥1.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  count enable.
- `clr`  in  1  synchronous clear.
- `div_load`  in  1  request a divisor change; sampled on each edge.
- `div_in`  in  CNT_W  new divisor.
- `pending`  out  1  a loaded divisor is waiting to take effect.
- `tick`  out  1  one-cycle pulse, once per divisor period.
- `sq`  out  1  square wave; toggles with each tick.
- `slow_tick`  out  1  one-cycle pulse every `SLOW_DIV` ticks; cascade feature only.

## Operation
- Registers: `cnt` [CNT_W], `div_q` (active divisor), `div_sh` (shadow divisor), `pending`, `tick`, `sq`, plus `slow_cnt` when the cascade is built.
- Reset (`rst_n`=0, asynchronous): `cnt`=0, `div_q`=`div_sh`=DIV_DEFAULT, `pending`=0, `tick`=0, `sq`=0, `slow_cnt`=0, `slow_tick`=0.
- Divisor clamp: a `div_in` of 0 is treated as 1 everywhere.
- Each edge is evaluated in priority order; the first matching rule applies:
  - **`clr`=1:**
    - `cnt`=0, `tick`=0, `sq`=0, `slow_cnt`=0, `slow_tick`=0.
    - If `pending`=1, `div_q`←`div_sh` and `pending`←0.
    - A `div_load` on the same edge goes directly into `div_q` and leaves `pending` at 0.
  - **`en`=0:**
    - `cnt`, `sq` and `slow_cnt` hold; `tick`=0 and `slow_tick`=0.
  - **`en`=1 and `cnt`==`div_q`−1 (terminal count):**
    - `cnt`←0, `tick`←1, `sq`←~`sq`.
    - If `pending`=1, `div_q`←`div_sh` and `pending`←0.
  - **`en`=1, otherwise:**
    - `cnt`←`cnt`+1, `tick`←0.
- Reload handshake (`div_load`=1 without `clr`):
  - `div_sh`←clamped `div_in` and `pending`←1.
  - Repeated loads before the swap overwrite `div_sh`; the last one wins.
  - A load on the terminal-count edge is captured into `div_sh` only and takes effect at the following terminal count.
  - The current period always completes with the old divisor, so there are no runt periods.
- Divisor 1: the terminal count holds on every enabled edge, so `tick` stays high continuously while `en`=1 and `sq` toggles every cycle.
- Counter invariant: `cnt` < `div_q` at all times, so no wrap-around past 2^CNT_W is possible.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- With `en` held high from a cleared state, the D-th enabled edge sets `tick`; `tick` is high for exactly one cycle per D enabled cycles.
- `sq` period is 2·D enabled cycles; it rises on the first tick after reset or `clr`.
- `pending` rises on the edge after `div_load` is sampled. It falls on the terminal-count edge that applies the new divisor; the very next period uses the new D.
- Deasserting `en` stretches the period by the number of disabled cycles; no tick is lost or duplicated.
- `rst_n` asserted mid-period clears state immediately. After release, the first tick comes DIV_DEFAULT enabled edges later.

## Configuration
- Macro: `TICK_DIVIDER_CASCADE_EN`.
- **Defined:**
  - `slow_cnt` increments on each edge that sets `tick`.
  - When `slow_cnt`==`SLOW_DIV`−1, that same edge sets `slow_tick`=1 for one cycle and resets `slow_cnt` to 0.
  - `slow_tick` is therefore coincident with every `SLOW_DIV`-th `tick`.
- **Not defined:** `slow_cnt` is absent and `slow_tick` is tied to 0. The port remains, so the interface is identical in both builds.

## Test plan
- Reset release, `en`=1, CNT_W=4, DIV_DEFAULT=5 → `tick` high on edges 5, 10, 15; `sq`=1,0,1 after those edges.
- `div_load` with `div_in`=3 at edge 2 of a D=5 period → `pending`=1 until edge 5. Next ticks at edges 8 and 11; `pending`=0 from edge 5.
- `div_in`=0 load, then terminal count → behaves as D=1: `tick` constantly high and `sq` toggling every cycle.
- `en` low for 4 cycles mid-period with D=5 → next tick delayed exactly 4 cycles; `cnt` holds and `tick` stays 0 while disabled.
- `clr` with a pending load, with and without a simultaneous `div_load` → `cnt`=0, `sq`=0, `pending`=0. New divisor active in the next period; `div_in` wins when `div_load` coincides.
- Cascade build, D=2, SLOW_DIV=3 → `slow_tick` on edges 6 and 12 only, coincident with `tick`. Non-cascade build → `slow_tick` stays 0.
